// File: rtl/pcie_comma_aligner.sv
// PCIe Rx symbol aligner: hunts K28.5 commas in a 1-bit/clk stream, frames 10-bit symbols, tracks lock.
// Optional macro COMMA_REALIGN_EN: a misaligned comma while LOCKED forces an immediate realign.
module pcie_comma_aligner #(
  parameter int LOCK_COMMAS = 2,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       disp_err,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       comma_det,
  output logic       locked
);
  localparam int CW = $clog2(LOCK_COMMAS + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [9:0]      sr_q, sr_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   comma_cnt_q, comma_cnt_d, comma_inc;
  logic [EW-1:0]   err_cnt_q, err_cnt_d, err_inc;
  logic [9:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            det_q, det_d;
  logic            locked_q, locked_d;
  logic            match, boundary;

  always_comb begin
    sr_d        = {sr_q[8:0], serial_in};
    match       = (sr_d == K285_N) || (sr_d == K285_P);
    boundary    = (bit_cnt_q == 4'd9);
    comma_inc   = (comma_cnt_q == '1) ? comma_cnt_q : comma_cnt_q + CW'(1);
    err_inc     = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + EW'(1);
    state_d     = state_q;
    bit_cnt_d   = boundary ? 4'd0 : bit_cnt_q + 4'd1;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    valid_d     = 1'b0;
    det_d       = 1'b0;
    locked_d    = locked_q;

    case (state_q)
      HUNT: begin
        if (match) begin
          valid_d     = 1'b1;
          det_d       = 1'b1;
          bit_cnt_d   = 4'd0;
          comma_cnt_d = CW'(1);
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (boundary) begin
          valid_d = 1'b1;
          det_d   = match;
          if (match) begin
            comma_cnt_d = comma_inc;
            if (comma_inc == CW'(LOCK_COMMAS)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end
        end else if (match) begin
          valid_d     = 1'b1;
          det_d       = 1'b1;
          bit_cnt_d   = 4'd0;
          comma_cnt_d = CW'(1);
        end
      end
      LOCKED: begin
        if (boundary) begin
          valid_d = 1'b1;
          det_d   = match;
        end
        // checker's err lines up with the cycle our data_valid is high
        if (valid_q) begin
          if (disp_err) begin
            err_cnt_d = err_inc;
            if (err_inc == EW'(UNLOCK_ERRS)) begin
              state_d     = HUNT;
              locked_d    = 1'b0;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
            end
          end else begin
            err_cnt_d = '0;
          end
        end
`ifdef COMMA_REALIGN_EN
        if (match && !boundary) begin
          valid_d     = 1'b1;
          det_d       = 1'b1;
          bit_cnt_d   = 4'd0;
          locked_d    = 1'b0;
          comma_cnt_d = CW'(1);
          err_cnt_d   = '0;
          state_d     = CHECK;
        end
`endif
      end
      default: state_d = HUNT;
    endcase

    data_d = valid_d ? sr_d : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      det_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      det_q       <= det_d;
      locked_q    <= locked_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign comma_det  = det_q;
  assign locked     = locked_q;
endmodule
